// File: rtl/pipelined_hybrid_adder_if.sv
// Operand/result bus of the pipelined hybrid adder.
// The adder is the slave; whoever feeds operands and takes results is the master.
interface pipelined_hybrid_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_hybrid_adder.sv
// WIDTH-bit add/subtract computed one BLOCK-bit slice per pipeline stage,
// with registered inter-slice carries and a final flag/output register stage.
module pipelined_hybrid_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_hybrid_adder_if.slave bus
);
  localparam int NBLK = WIDTH / BLOCK;

  // Handshake: a beat transfers on a rising edge where valid && ready. A result
  // held without out_ready freezes the whole pipe and drops in_ready.

  // Slice 0: explicit carry lookahead, each carry as a flat sum of products.
  function automatic logic [BLOCK:0] cla_slice(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic ci);
    logic [BLOCK-1:0] g, p;
    logic [BLOCK:0]   c;
    logic             term;
    g = x & y;
    p = x ^ y;
    c = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  // Upper slices: Kogge-Stone prefix tree with the carry-in folded into bit 0.
  function automatic logic [BLOCK:0] ksa_slice(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic ci);
    logic [BLOCK-1:0] p, gg, pp, gn, pn;
    logic [BLOCK:0]   c;
    p  = x ^ y;
    gg = x & y;
    pp = p;
    gg[0] = gg[0] | (p[0] & ci);
    for (int d = 1; d < BLOCK; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = d; i < BLOCK; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    c = {gg, ci};
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  logic [WIDTH-1:0] r_a [NBLK];
  logic [WIDTH-1:0] r_b [NBLK];
  logic [WIDTH-1:0] r_s [NBLK];
  logic             r_c [NBLK];
  logic             r_v [NBLK];
  logic             r_rdy;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [WIDTH-1:0] w_a_in [NBLK];
  logic [WIDTH-1:0] w_b_in [NBLK];
  logic [WIDTH-1:0] w_s_in [NBLK];
  logic [WIDTH-1:0] w_s_nxt [NBLK];
  logic             w_c_in [NBLK];
  logic             w_v_in [NBLK];
  logic [BLOCK:0]   w_add  [NBLK];
  logic             w_stall;

  assign w_stall = r_out_vld & ~bus.out_ready;

  always_comb begin
    w_a_in[0] = bus.a;
    w_b_in[0] = bus.sub ? ~bus.b : bus.b;
    w_c_in[0] = bus.sub | bus.cin;
    w_s_in[0] = '0;
    w_v_in[0] = bus.in_valid & r_rdy;
    for (int k = 1; k < NBLK; k++) begin
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_c_in[k] = r_c[k-1];
      w_s_in[k] = r_s[k-1];
      w_v_in[k] = r_v[k-1];
    end
    for (int k = 0; k < NBLK; k++) begin
      if (k == 0) begin
        w_add[k] = cla_slice(w_a_in[k][k*BLOCK +: BLOCK], w_b_in[k][k*BLOCK +: BLOCK], w_c_in[k]);
      end else begin
        w_add[k] = ksa_slice(w_a_in[k][k*BLOCK +: BLOCK], w_b_in[k][k*BLOCK +: BLOCK], w_c_in[k]);
      end
      w_s_nxt[k] = w_s_in[k];
      w_s_nxt[k][k*BLOCK +: BLOCK] = w_add[k][BLOCK-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NBLK; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
      r_rdy     <= 1'b0;
      r_out_vld <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      if (!w_stall) begin
        for (int k = 0; k < NBLK; k++) begin
          r_a[k] <= w_a_in[k];
          r_b[k] <= w_b_in[k];
          r_s[k] <= w_s_nxt[k];
          r_c[k] <= w_add[k][BLOCK];
          r_v[k] <= w_v_in[k];
        end
        // Flags are derived from the fully assembled last-stage word.
        r_out_vld <= r_v[NBLK-1];
        r_sum     <= r_s[NBLK-1];
        r_cout    <= r_c[NBLK-1];
        r_ovf     <= (r_a[NBLK-1][WIDTH-1] == r_b[NBLK-1][WIDTH-1]) &&
                     (r_s[NBLK-1][WIDTH-1] != r_a[NBLK-1][WIDTH-1]);
        r_zero    <= (r_s[NBLK-1] == '0);
      end
    end
  end

  assign bus.in_ready  = r_rdy & ~w_stall;
  assign bus.out_valid = r_out_vld;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_pipelined_hybrid_adder.sv
// Bench for pipelined_hybrid_adder (WIDTH=16, BLOCK=4): directed vector table,
// handshake corner sequences and random traffic against an arithmetic model.
module tb_pipelined_hybrid_adder;
  localparam int W   = 16;
  localparam int LAT = 4;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;

  logic [W+2:0] exp_q[$];

  pipelined_hybrid_adder_if #(.WIDTH(W)) ifc ();

  pipelined_hybrid_adder #(.WIDTH(W), .BLOCK(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Plain integer arithmetic: returns {sum, cout, ovf, zero}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
    int sa, sbv, res, ua, ub, u;
    logic [W-1:0] s;
    logic co, ov;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = a;
    ub  = b;
    if (sb) begin
      res = sa - sbv;
      u   = ua - ub;
      co  = (ua >= ub);
    end else begin
      res = sa + sbv + int'(ci);
      u   = ua + ub + int'(ci);
      co  = (u > 65535);
    end
    s  = u[W-1:0];
    ov = (res > 32767) || (res < -32768);
    return {s, co, ov, (s == '0)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / protocol monitor ----------------
  logic         prev_stall = 1'b0;
  logic [W+2:0] prev_data;
  logic [W+2:0] got;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      got = {ifc.sum, ifc.cout, ifc.ovf, ifc.zero};
      if (prev_stall) begin
        check("hold_valid", 32'(ifc.out_valid), 32'd1);
        check("hold_data", 32'(got), 32'(prev_data));
      end
      if (ifc.out_valid && ifc.out_ready) begin
        n_out++;
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("scoreboard", 32'(got), 32'(exp_q.pop_front()));
      end
      if (ifc.in_valid && ifc.in_ready)
        exp_q.push_back(model(ifc.a, ifc.b, ifc.cin, ifc.sub));
      prev_stall = ifc.out_valid && !ifc.out_ready;
      prev_data  = got;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb, output int lat);
    ifc.in_valid  = 1'b1;
    ifc.a         = a;
    ifc.b         = b;
    ifc.cin       = ci;
    ifc.sub       = sb;
    ifc.out_ready = 1'b1;
    step();
    ifc.in_valid = 1'b0;
    lat = 0;
    while (!ifc.out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
    logic         e_zero;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, first, last, cnt, sent, stall_left, base;
    logic acc, stall_done, bad;
    logic [W-1:0] ra, rb;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};

    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.cin       = 1'b0;
    ifc.sub       = 1'b0;
    ifc.out_ready = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_sum", 32'(ifc.sum), 32'd0);
    check("rst_flags", 32'({ifc.cout, ifc.ovf, ifc.zero}), 32'd0);
    check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);

    // Directed vectors, one beat at a time
    foreach (vecs[i]) begin
      run_beat(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      check("vec_latency", 32'(lat), 32'(LAT));
      check("vec_sum", 32'(ifc.sum), 32'(vecs[i].e_sum));
      check("vec_cout", 32'(ifc.cout), 32'(vecs[i].e_cout));
      check("vec_ovf", 32'(ifc.ovf), 32'(vecs[i].e_ovf));
      check("vec_zero", 32'(ifc.zero), 32'(vecs[i].e_zero));
      step();
      check("vec_bubble", 32'(ifc.out_valid), 32'd0);
    end

    // Back-to-back stream of 8 beats
    first = -1; last = -1; cnt = 0;
    ifc.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (ifc.out_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
      ifc.in_valid = (c < 8);
      ifc.a   = 16'(c + 1);
      ifc.b   = 16'(16'h0101 * (c + 1));
      ifc.cin = 1'b0;
      ifc.sub = 1'b0;
      step();
    end
    check("stream_count", 32'(cnt), 32'd8);
    check("stream_no_gaps", 32'(last - first), 32'd7);

    // Backpressure: 6 beats, out_ready low for 3 cycles once results appear
    base = n_out; sent = 0; stall_left = 0; stall_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!stall_done && ifc.out_valid) begin
        stall_left = 3;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        ifc.out_ready = 1'b0;
        stall_left--;
      end else begin
        ifc.out_ready = 1'b1;
      end
      ifc.in_valid = (sent < 6);
      ifc.a   = 16'(16'h0100 + sent);
      ifc.b   = 16'(16'h0010 * sent);
      ifc.sub = sent[0];
      @(negedge clk);
      if (!ifc.out_ready) check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      acc = ifc.in_valid && ifc.in_ready;
      step();
      if (acc) sent++;
    end
    check("bp_sent", 32'(sent), 32'd6);
    check("bp_received", 32'(n_out - base), 32'd6);

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      ifc.a   = 16'($urandom);
      ifc.b   = 16'($urandom);
      ifc.cin = 1'($urandom_range(0, 1));
      ifc.sub = 1'($urandom_range(0, 1));
      step();
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (10) step();
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with beats in flight
    for (int c = 0; c < 6; c++) begin
      ifc.in_valid = 1'b1;
      ifc.a   = 16'(16'h0A00 + c);
      ifc.b   = 16'h0003;
      ifc.cin = 1'b0;
      ifc.sub = 1'b0;
      step();
    end
    ifc.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("arst_sum", 32'(ifc.sum), 32'd0);
    check("arst_in_ready", 32'(ifc.in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ifc.out_valid) bad = 1'b1;
    end
    check("arst_no_stale", 32'(bad), 32'd0);
    run_beat(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
    check("arst_new_latency", 32'(lat), 32'(LAT));
    check("arst_new_sum", 32'(ifc.sum), 32'h0002);
    repeat (3) step();

    // Small random burst compared directly against the model
    for (int c = 0; c < 6; c++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_beat(ra, rb, 1'b0, 1'(c % 2), lat);
      check("rand_beat", 32'({ifc.sum, ifc.cout, ifc.ovf, ifc.zero}), 32'(model(ra, rb, 1'b0, 1'(c % 2))));
      step();
    end
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipelined_hybrid_adder.md
Name: pipelined_hybrid_adder

Overview:
- Parametrised, pipelined successor to the team's 8-bit hybrid CLA/KSA adder.
- Adds or subtracts WIDTH-bit operands in BLOCK-bit slices, one slice per pipeline stage; the carry between slices passes through a register.
- Uses a valid/ready handshake on both sides and reports carry, signed overflow and zero flags.
- Sits between operand registers and the datapath result bus in the TT tile top level.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of BLOCK, minimum 8.
- BLOCK, 4, slice width computed per stage.
- NBLK, WIDTH/BLOCK, derived (localparam): number of stages, which equals the latency.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for sub, 1 means no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- While rst_n=0:
  - All stage valid bits, carry registers, skew registers and outputs are 0.
  - in_ready is 0 while reset is asserted and 1 from the first cycle after release.
- Input conditioning at stage 0: b_eff = sub ? ~b : b; c_in_eff = sub ? 1 : cin.
- Stage k (0..NBLK-1):
  - Adds slice k of a and b_eff plus the registered carry from stage k-1 (stage 0 uses c_in_eff).
  - Registers the slice sum, the carry out and a valid bit.
  - Slice 0 uses CLA lookahead logic; slices 1..NBLK-1 use Kogge-Stone prefix logic. Results must be bit-identical to a reference WIDTH-bit adder.
- Skew alignment:
  - Unconsumed operand slices travel down delay registers to the stage that uses them.
  - Finished sum slices travel down delay registers so that all slices of one beat emerge together.
- Latency: exactly NBLK cycles from the accepting edge to out_valid, with no stalls. Throughput is 1 beat/cycle.
- Transfer rules:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready.
- Stall:
  - stall = out_valid && !out_ready. It freezes every pipeline register, including the valid bits.
  - in_ready = !stall.
  - Holding out_valid with sum/cout/ovf/zero stable until accepted is mandatory.
- Bubbles: in_valid=0 inserts a bubble whose data registers may hold any value. out_valid must be 0 for bubbles.
- ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), computed on the final slice. zero is a registered reduction of the assembled sum. All flags update together with sum.
- out_ready may be high while out_valid=0 with no effect. in_valid is ignored while in_ready=0, and the beat is not captured.
- Simultaneous output accept and new input in the same cycle: both transfer, so a full pipeline keeps streaming.
- Reset mid-operation: in-flight beats are discarded, and no partial result ever appears at the output.
- Outputs come directly from registers; there is no combinational path from a/b to the outputs.
- The only combinational input-to-output path is out_ready to in_ready, a single gate level.

Test Plan (WIDTH=16, BLOCK=4, latency 4):
- Reset, then a=0x1234, b=0x1111, cin=0, sub=0, out_ready=1 -> out_valid high exactly 4 cycles later; sum=0x2345, cout=0, ovf=0, zero=0.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, zero=1, ovf=0. Checks the carry rippling through all four registered stages.
- Subtract: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1. Then a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
- Back-to-back stream of 8 beats (a=i, b=0x0101*i, i=1..8) with out_ready=1 -> 8 consecutive out_valid cycles, in order, each sum=a+b, no gaps.
- Backpressure: stream 6 beats, drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, the held result is stable, no beat is lost or duplicated, and the order is preserved.
- Assert rst_n=0 asynchronously (mid-clock) with 3 beats in flight -> outputs and out_valid go 0 immediately; after release, none of the 3 beats appears. A new beat 0x0001+0x0001 returns 0x0002 after 4 cycles.
